// File: rtl/irq_dispatch.sv
// irq_dispatch
//   Takes a request from the interrupt controller and steers the core into
//   the handler. The core must be at an instruction boundary for this to
//   happen. For a maskable request the block pushes the return PC onto the
//   stack, reads the 16-bit handler vector from the vector table, loads the
//   PC and acknowledges the controller. It also owns the global interrupt
//   enable flag (IE).
//
//   Optional feature: define IRQ_PUSH_FLAGS_EN to add the FLAGS_IN port.
//   A third byte (the flags) is then pushed after the PC low byte.
//
// Ports
//   CLK, RST            clock (rising edge), async active-low reset
//   NEXT_ID/NEXT_ON     pending maskable interrupt id / request
//   RESET_ON            non-maskable reset request (vectors, no push)
//   ACK                 one-cycle "serviced" pulse to the controller
//   INSTR_DONE          core is at an instruction boundary
//   EI / DI             set / clear IE (DI wins)
//   PC_IN, SP_IN        return PC and current stack pointer from the core
//   SP_DEC              core decrements SP (one pulse per pushed byte)
//   BUS_*               single-master byte bus; the request is held until BUS_ACK
//   PC_LOAD, PC_NEW     core loads the handler address
//   BUSY                a sequence is in progress; core stalls fetch
//   IE                  interrupt-enable flag
//   FLAGS_IN            (IRQ_PUSH_FLAGS_EN only) flags byte to push
module irq_dispatch #(
  parameter logic [15:0] VEC_BASE = 16'hFFE0,
  parameter int unsigned SP_W     = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [3:0]      NEXT_ID,
  input  logic            NEXT_ON,
  input  logic            RESET_ON,
  output logic            ACK,
  input  logic            INSTR_DONE,
  input  logic            EI,
  input  logic            DI,
  input  logic [15:0]     PC_IN,
  input  logic [SP_W-1:0] SP_IN,
`ifdef IRQ_PUSH_FLAGS_EN
  input  logic [7:0]      FLAGS_IN,
`endif
  output logic            SP_DEC,
  output logic            BUS_REQ,
  output logic            BUS_WE,
  output logic [15:0]     BUS_ADDR,
  output logic [7:0]      BUS_WDATA,
  input  logic [7:0]      BUS_RDATA,
  input  logic            BUS_ACK,
  output logic            PC_LOAD,
  output logic [15:0]     PC_NEW,
  output logic            BUSY,
  output logic            IE
);

  typedef enum logic [2:0] {
    IDLE,
    PUSH_HI,
    PUSH_LO,
    PUSH_FL,
    VEC_LO,
    VEC_HI,
    LOAD
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  id_q,    id_d;
  logic [15:0] pc_q,    pc_d;
  logic [15:0] vec_q,   vec_d;
  logic        ie_q,    ie_d;
`ifdef IRQ_PUSH_FLAGS_EN
  logic [7:0]  flags_q, flags_d;
`endif

  logic        accept_rst;
  logic        accept_irq;
  logic [15:0] stack_addr;
  logic [15:0] vec_addr_lo;
  logic [15:0] vec_addr_hi;

  // The core has already applied any SP decrement by the time each push
  // state is active, so every push targets the live SP_IN.
  assign stack_addr  = 16'h0100 + 16'(SP_IN);
  assign vec_addr_lo = VEC_BASE + {11'd0, id_q, 1'b0};
  assign vec_addr_hi = VEC_BASE + {11'd0, id_q, 1'b1};

  // RESET_ON beats a maskable request. It ignores IE and INSTR_DONE.
  assign accept_rst = (state_q == IDLE) && RESET_ON;
  assign accept_irq = (state_q == IDLE) && !RESET_ON && NEXT_ON && ie_q && INSTR_DONE;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    pc_d    = pc_q;
    vec_d   = vec_q;
`ifdef IRQ_PUSH_FLAGS_EN
    flags_d = flags_q;
`endif

    // An accept clears IE. This overrides a same-cycle EI.
    ie_d = ie_q;
    if (EI) ie_d = 1'b1;
    if (DI) ie_d = 1'b0;
    if (accept_rst || accept_irq) ie_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_rst || accept_irq) begin
          id_d    = NEXT_ID;
          pc_d    = PC_IN;
`ifdef IRQ_PUSH_FLAGS_EN
          flags_d = FLAGS_IN;
`endif
          state_d = accept_rst ? VEC_LO : PUSH_HI;
        end
      end
      PUSH_HI: if (BUS_ACK) state_d = PUSH_LO;
      PUSH_LO: begin
        if (BUS_ACK) begin
`ifdef IRQ_PUSH_FLAGS_EN
          state_d = PUSH_FL;
`else
          state_d = VEC_LO;
`endif
        end
      end
`ifdef IRQ_PUSH_FLAGS_EN
      PUSH_FL: if (BUS_ACK) state_d = VEC_LO;
`endif
      VEC_LO: begin
        if (BUS_ACK) begin
          vec_d[7:0] = BUS_RDATA;
          state_d    = VEC_HI;
        end
      end
      VEC_HI: begin
        if (BUS_ACK) begin
          vec_d[15:8] = BUS_RDATA;
          state_d     = LOAD;
        end
      end
      LOAD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode from the registered state only. An async reset
  // therefore drops the bus request immediately.
  always_comb begin
    ACK       = 1'b0;
    PC_LOAD   = 1'b0;
    SP_DEC    = 1'b0;
    BUS_REQ   = 1'b0;
    BUS_WE    = 1'b0;
    BUS_ADDR  = '0;
    BUS_WDATA = '0;
    case (state_q)
      PUSH_HI: begin
        BUS_REQ   = 1'b1;
        BUS_WE    = 1'b1;
        BUS_ADDR  = stack_addr;
        BUS_WDATA = pc_q[15:8];
        SP_DEC    = BUS_ACK;
      end
      PUSH_LO: begin
        BUS_REQ   = 1'b1;
        BUS_WE    = 1'b1;
        BUS_ADDR  = stack_addr;
        BUS_WDATA = pc_q[7:0];
        SP_DEC    = BUS_ACK;
      end
`ifdef IRQ_PUSH_FLAGS_EN
      PUSH_FL: begin
        BUS_REQ   = 1'b1;
        BUS_WE    = 1'b1;
        BUS_ADDR  = stack_addr;
        BUS_WDATA = flags_q;
        SP_DEC    = BUS_ACK;
      end
`endif
      VEC_LO: begin
        BUS_REQ  = 1'b1;
        BUS_ADDR = vec_addr_lo;
      end
      VEC_HI: begin
        BUS_REQ  = 1'b1;
        BUS_ADDR = vec_addr_hi;
      end
      LOAD: begin
        PC_LOAD = 1'b1;
        ACK     = 1'b1;
      end
      default: ;
    endcase
  end

  assign PC_NEW = vec_q;
  assign BUSY   = (state_q != IDLE);
  assign IE     = ie_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      id_q    <= '0;
      pc_q    <= '0;
      vec_q   <= '0;
      ie_q    <= 1'b0;
`ifdef IRQ_PUSH_FLAGS_EN
      flags_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      pc_q    <= pc_d;
      vec_q   <= vec_d;
      ie_q    <= ie_d;
`ifdef IRQ_PUSH_FLAGS_EN
      flags_q <= flags_d;
`endif
    end
  end

endmodule

// File: tb/tb_irq_dispatch.sv
module tb_irq_dispatch;

`ifdef IRQ_PUSH_FLAGS_EN
  localparam int unsigned FRAME = 3;
`else
  localparam int unsigned FRAME = 2;
`endif

  logic        CLK, RST;
  logic [3:0]  NEXT_ID;
  logic        NEXT_ON, RESET_ON, ACK, INSTR_DONE, EI, DI;
  logic [15:0] PC_IN;
  logic [7:0]  SP_IN;
`ifdef IRQ_PUSH_FLAGS_EN
  logic [7:0]  FLAGS_IN;
`endif
  logic        SP_DEC, BUS_REQ, BUS_WE;
  logic [15:0] BUS_ADDR;
  logic [7:0]  BUS_WDATA, BUS_RDATA;
  logic        BUS_ACK, PC_LOAD;
  logic [15:0] PC_NEW;
  logic        BUSY, IE;

  irq_dispatch #(.VEC_BASE(16'hFFE0), .SP_W(8)) dut (
    .CLK(CLK), .RST(RST), .NEXT_ID(NEXT_ID), .NEXT_ON(NEXT_ON),
    .RESET_ON(RESET_ON), .ACK(ACK), .INSTR_DONE(INSTR_DONE), .EI(EI), .DI(DI),
    .PC_IN(PC_IN), .SP_IN(SP_IN),
`ifdef IRQ_PUSH_FLAGS_EN
    .FLAGS_IN(FLAGS_IN),
`endif
    .SP_DEC(SP_DEC), .BUS_REQ(BUS_REQ), .BUS_WE(BUS_WE), .BUS_ADDR(BUS_ADDR),
    .BUS_WDATA(BUS_WDATA), .BUS_RDATA(BUS_RDATA), .BUS_ACK(BUS_ACK),
    .PC_LOAD(PC_LOAD), .PC_NEW(PC_NEW), .BUSY(BUSY), .IE(IE)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // bench-side model state
  logic [7:0]  vec_mem [32];
  logic [7:0]  sp;
  bit          ie_m, ie_next, dec_pend, acc;
  bit          in_txn, t_we;
  logic [15:0] t_addr;
  logic [7:0]  t_wd;
  int unsigned wait_left, waits_cfg, n_dec;
  logic [15:0] wr_a[$], rd_a[$];
  logic [7:0]  wr_d[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] rom(input logic [15:0] a);
    return (a >= 16'hFFE0) ? vec_mem[a[4:0]] : 8'h00;
  endfunction

  // Called at a falling edge after the inputs are set. It acts as the bus
  // slave, checks IE and predicts IE after the next rising edge.
  task automatic eval();
    #1;
    BUS_ACK   = 1'b0;
    BUS_RDATA = 8'($urandom);
    if (BUS_REQ) begin
      if (!in_txn) begin
        in_txn = 1; t_addr = BUS_ADDR; t_we = BUS_WE; t_wd = BUS_WDATA;
        wait_left = waits_cfg;
      end else begin
        check("bus_addr_stable", BUS_ADDR, t_addr);
        check("bus_we_stable", BUS_WE, t_we);
        if (t_we) check("bus_wdata_stable", BUS_WDATA, t_wd);
      end
      if (wait_left > 0) wait_left--;
      else begin
        BUS_ACK = 1'b1;
        in_txn  = 0;
        if (t_we) begin wr_a.push_back(t_addr); wr_d.push_back(t_wd); end
        else begin rd_a.push_back(t_addr); BUS_RDATA = rom(t_addr); end
      end
    end
    #1;
    check("ie", IE, ie_m);
    if (SP_DEC) n_dec++;
    dec_pend = SP_DEC;
    acc      = !BUSY && (RESET_ON || (NEXT_ON && ie_m && INSTR_DONE));
    ie_next  = acc ? 1'b0 : (DI ? 1'b0 : (EI ? 1'b1 : ie_m));
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
    if (dec_pend) sp = sp - 8'd1;
    SP_IN    = sp;
    ie_m     = ie_next;
    dec_pend = 0;
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    NEXT_ON = 0; RESET_ON = 0; INSTR_DONE = 0; EI = 0; DI = 0;
  endtask

  task automatic run_irq(input bit is_rst, input logic [3:0] id, input logic [15:0] pc,
                         input logic [7:0] sp0, input int unsigned waits,
                         input logic [7:0] fl, input bit ei_at_acc);
    int unsigned lat, lat_exp, nw;
    logic [15:0] lo_a, exp_a[$];
    logic [7:0]  exp_d[$];
    waits_cfg = waits;
    sp = sp0; SP_IN = sp;
    if (!is_rst && !ie_m) begin
      idle_inputs(); NEXT_ON = 1; INSTR_DONE = 1; EI = 1; NEXT_ID = id;
      eval(); next_cycle();
    end
    if (!is_rst) begin
      for (int i = 0; i < int'($urandom_range(0, 2)); i++) begin
        idle_inputs(); NEXT_ON = 1; NEXT_ID = id;
        eval(); next_cycle();
      end
    end
    idle_inputs();
    NEXT_ID = id; PC_IN = pc;
`ifdef IRQ_PUSH_FLAGS_EN
    FLAGS_IN = fl;
`endif
    if (is_rst) begin
      RESET_ON = 1; NEXT_ON = 1'($urandom); INSTR_DONE = 1'($urandom);
    end else begin
      NEXT_ON = 1; INSTR_DONE = 1; EI = ei_at_acc;
    end
    wr_a.delete(); wr_d.delete(); rd_a.delete(); n_dec = 0;
    eval();
    check("idle_before_accept", BUSY, 0);
    next_cycle();
    lat = 0;
    for (int c = 1; c <= 60; c++) begin
      NEXT_ON = 1'($urandom); RESET_ON = ($urandom_range(0, 3) == 0);
      INSTR_DONE = 1'($urandom); EI = ($urandom_range(0, 7) == 0);
      DI = ($urandom_range(0, 7) == 0); PC_IN = 16'($urandom); NEXT_ID = 4'($urandom);
`ifdef IRQ_PUSH_FLAGS_EN
      FLAGS_IN = 8'($urandom);
`endif
      eval();
      check("busy_in_seq", BUSY, 1);
      if (PC_LOAD) begin lat = c; break; end
      next_cycle();
    end
    nw      = is_rst ? 0 : FRAME;
    lat_exp = nw + 3 + waits * (nw + 2);
    lo_a    = 16'hFFE0 + 16'(id) * 16'd2;
    check("latency", lat, lat_exp);
    check("ack_with_load", ACK, 1);
    check("pc_new", PC_NEW, {rom(lo_a + 16'd1), rom(lo_a)});
    check("no_req_in_load", BUS_REQ, 0);
    next_cycle();
    idle_inputs();
    eval();
    check("idle_after_load", BUSY, 0);
    check("load_one_cycle", PC_LOAD, 0);
    next_cycle();
    // expected frame, computed from the stacking rule
    if (!is_rst) begin
      exp_a.push_back(16'h0100 + 16'(sp0));            exp_d.push_back(pc[15:8]);
      exp_a.push_back(16'h0100 + 16'(8'(sp0 - 8'd1))); exp_d.push_back(pc[7:0]);
      if (FRAME == 3) begin
        exp_a.push_back(16'h0100 + 16'(8'(sp0 - 8'd2))); exp_d.push_back(fl);
      end
    end
    check("write_count", wr_a.size(), nw);
    check("sp_dec_count", n_dec, nw);
    for (int i = 0; i < int'(nw) && i < wr_a.size(); i++) begin
      check("write_addr", wr_a[i], exp_a[i]);
      check("write_data", wr_d[i], exp_d[i]);
    end
    check("read_count", rd_a.size(), 2);
    if (rd_a.size() == 2) begin
      check("read_addr_lo", rd_a[0], lo_a);
      check("read_addr_hi", rd_a[1], lo_a + 16'd1);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] spm;
    for (int i = 0; i < 32; i++) vec_mem[i] = 8'($urandom);
    RST = 0; idle_inputs(); NEXT_ID = 0; PC_IN = 0; sp = 8'hFF; SP_IN = sp;
    BUS_ACK = 0; BUS_RDATA = 0; waits_cfg = 0;
`ifdef IRQ_PUSH_FLAGS_EN
    FLAGS_IN = 0;
`endif
    ie_m = 0; ie_next = 0; dec_pend = 0; in_txn = 0;
    #3;
    check("rst_busy", BUSY, 0);
    check("rst_ie", IE, 0);
    check("rst_bus_req", BUS_REQ, 0);
    check("rst_pc_load", PC_LOAD, 0);
    check("rst_ack", ACK, 0);
    check("rst_pc_new", PC_NEW, 0);
    @(negedge CLK);
    RST = 1;

    // masked: request with IE=0 must not be taken
    for (int i = 0; i < 4; i++) begin
      idle_inputs(); NEXT_ON = 1; INSTR_DONE = 1; NEXT_ID = 4'd5;
      eval();
      check("masked_busy", BUSY, 0);
      check("masked_bus_req", BUS_REQ, 0);
      next_cycle();
    end

    run_irq(0, 4'd3, 16'h1234, 8'hFF, 0, 8'hA5, 1);   // directed maskable, EI at accept
    run_irq(1, 4'd0, 16'h5555, 8'h80, 0, 8'h00, 0);   // reset vector
    run_irq(0, 4'd7, 16'hBEEF, 8'h01, 2, 8'h3C, 0);   // wait states, SP wrap
    run_irq(0, 4'd15, 16'h0000, 8'h00, 1, 8'hFF, 0);  // top vector entry
    for (int n = 0; n < 30; n++)
      run_irq($urandom_range(0, 3) == 0, 4'($urandom), 16'($urandom), 8'($urandom),
              $urandom_range(0, 2), 8'($urandom), 1'($urandom));

    // IE only: random EI/DI pulses in idle
    for (int i = 0; i < 20; i++) begin
      idle_inputs(); EI = 1'($urandom); DI = 1'($urandom);
      eval(); next_cycle();
    end

    // async reset in the middle of PUSH_LO
    idle_inputs(); EI = 1; eval(); next_cycle();
    waits_cfg = 3; sp = 8'h40; SP_IN = sp; spm = 8'h3F;
    idle_inputs(); NEXT_ON = 1; INSTR_DONE = 1; PC_IN = 16'hCAFE; NEXT_ID = 4'd2;
    eval(); next_cycle();
    begin
      bit found = 0;
      for (int c = 0; c < 20; c++) begin
        idle_inputs(); eval();
        if (BUS_REQ && BUS_WE && BUS_ADDR == 16'h0100 + 16'(spm)) begin found = 1; break; end
        next_cycle();
      end
      check("reach_push_lo", found, 1);
    end
    RST = 0;
    #1;
    check("async_bus_req", BUS_REQ, 0);
    check("async_busy", BUSY, 0);
    check("async_ie", IE, 0);
    check("async_pc_new", PC_NEW, 0);
    check("async_sp_dec", SP_DEC, 0);
    ie_m = 0; ie_next = 0; in_txn = 0; dec_pend = 0; BUS_ACK = 0;
    @(posedge CLK);
    @(negedge CLK);
    RST = 1;
    for (int i = 0; i < 3; i++) begin
      idle_inputs(); NEXT_ON = 1; INSTR_DONE = 1;
      eval();
      check("post_rst_idle", BUSY, 0);
      check("post_rst_no_req", BUS_REQ, 0);
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
